apb_req_arbiter: RTL and testbench

- Two-port APB master that shares one APB slave (32x32 register memory, P_* bus) between two requesters.
- Arbitrates pending requests round-robin and sequences each one through the APB SETUP and ACCESS phases.
- Returns read data and error status to the granted requester.
- Guards every transfer with a P_ready timeout so a hung slave cannot stall both requesters.

---
 rtl/apb_req_arbiter.sv | 168 ++++++++++++++++
 tb/tb_apb_req_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Two-requester APB master: round-robin arbitration in IDLE, then SETUP/ACCESS sequencing
// toward a single APB slave. A P_ready timeout aborts hung transfers with an error response.
module apb_req_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                P_clk,
  input  logic                P_rst,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_accept,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   P_addr,
  output logic                P_selx,
  output logic                P_enable,
  output logic                P_write,
  output logic [DATA_W-1:0]   P_wdata,
  input  logic                P_ready,
  input  logic                P_slverr,
  input  logic [DATA_W-1:0]   P_rdata,
  output logic [1:0]          dbg_state_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Handshake: a requester raises req_valid with a stable payload and holds it until
  // the cycle in which req_accept for its index is high; the payload is captured at
  // the end of that cycle. rsp_valid is a one-cycle pulse with no back-pressure.

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [1:0] grant;
  logic       gnt_idx;

  // When both request, the one that was not granted last wins.
  always_comb begin
    grant = 2'b00;
    if (state_q == ST_IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign gnt_idx    = grant[1];
  assign req_accept = grant;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_valid_d = 2'b00;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          paddr_d   = gnt_idx ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
          pwdata_d  = gnt_idx ? req_wdata[2*DATA_W-1:DATA_W]  : req_wdata[DATA_W-1:0];
          pwrite_d  = gnt_idx ? req_write[1] : req_write[0];
          last_d    = gnt_idx;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (P_ready) begin
          rsp_valid_d[last_q] = 1'b1;
          rsp_err_d           = P_slverr;
          rsp_rdata_d         = pwrite_q ? '0 : P_rdata;
          psel_d              = 1'b0;
          penable_d           = 1'b0;
          cnt_d               = '0;
          state_d             = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rsp_valid_d[last_q] = 1'b1;
          rsp_err_d           = 1'b1;
          psel_d              = 1'b0;
          penable_d           = 1'b0;
          cnt_d               = '0;
          state_d             = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        cnt_d     = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge P_clk or negedge P_rst) begin
    if (!P_rst) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign P_addr      = paddr_q;
  assign P_wdata     = pwdata_q;
  assign P_write     = pwrite_q;
  assign P_selx      = psel_q;
  assign P_enable    = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a 32x32 APB register-memory slave model.
// Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
module tb_apb_req_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic                P_clk;
  logic                P_rst;
  logic [1:0]          req_valid;
  logic [1:0]          req_write;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_accept;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic [ADDR_W-1:0]   P_addr;
  logic                P_selx;
  logic                P_enable;
  logic                P_write;
  logic [DATA_W-1:0]   P_wdata;
  logic                P_ready;
  logic                P_slverr;
  logic [DATA_W-1:0]   P_rdata;
  logic [1:0]          dbg_state;

  logic                slave_ready;
  logic                slave_err;
  logic [31:0]         mem [32];

  int n_cmp = 0;
  int n_err = 0;

  apb_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .P_clk(P_clk), .P_rst(P_rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_accept(req_accept), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .P_addr(P_addr), .P_selx(P_selx), .P_enable(P_enable), .P_write(P_write), .P_wdata(P_wdata),
    .P_ready(P_ready), .P_slverr(P_slverr), .P_rdata(P_rdata), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial P_clk = 1'b0;
  always #5 P_clk = ~P_clk;

  // slave model
  assign P_ready  = slave_ready;
  assign P_slverr = slave_err;
  assign P_rdata  = (P_selx && P_enable) ? mem[P_addr[4:0]] : 32'h0;

  always @(posedge P_clk) begin
    if (P_selx && P_enable && P_ready && P_write) mem[P_addr[4:0]] <= P_wdata;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle;
    @(posedge P_clk);
    #1;
  endtask

  task automatic mid;
    @(negedge P_clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    req_write[idx] = wr;
    req_addr[idx*ADDR_W +: ADDR_W]  = addr;
    req_wdata[idx*DATA_W +: DATA_W] = wdata;
  endtask

  logic [1:0] exp_g;
  logic [1:0] prev_g;
  int         n_acc;

  initial begin
    P_rst       = 1'b0;
    req_valid   = 2'b00;
    req_write   = 2'b00;
    req_addr    = '0;
    req_wdata   = '0;
    slave_ready = 1'b1;
    slave_err   = 1'b0;

    // reset state
    repeat (2) next_cycle();
    mid();
    chk("rst_selx", P_selx, 1'b0);
    chk("rst_enable", P_enable, 1'b0);
    chk("rst_addr", P_addr, 32'h0);
    chk("rst_wdata", P_wdata, 32'h0);
    chk("rst_write", P_write, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_state", dbg_state, 2'd0);
    next_cycle();
    P_rst = 1'b1;
    next_cycle();

    // req0 write 0xDEADBEEF to address 5
    set_req(0, 1'b1, 32'd5, 32'hDEADBEEF);
    req_valid = 2'b01;
    mid();
    chk("wr_accept", req_accept, 2'b01);
    next_cycle();
    req_valid = 2'b00;
    mid();
    chk("wr_setup_selx", P_selx, 1'b1);
    chk("wr_setup_enable", P_enable, 1'b0);
    chk("wr_setup_addr", P_addr, 32'd5);
    chk("wr_setup_wdata", P_wdata, 32'hDEADBEEF);
    chk("wr_setup_write", P_write, 1'b1);
    chk("wr_setup_accept", req_accept, 2'b00);
    next_cycle();
    mid();
    chk("wr_access_selx", P_selx, 1'b1);
    chk("wr_access_enable", P_enable, 1'b1);
    chk("wr_access_addr", P_addr, 32'd5);
    next_cycle();
    mid();
    chk("wr_rsp_valid", rsp_valid, 2'b01);
    chk("wr_rsp_err", rsp_err, 1'b0);
    chk("wr_rsp_rdata", rsp_rdata, 32'h0);
    chk("wr_rsp_selx", P_selx, 1'b0);
    chk("wr_rsp_enable", P_enable, 1'b0);
    chk("wr_hold_addr", P_addr, 32'd5);
    chk("wr_mem5", mem[5], 32'hDEADBEEF);
    next_cycle();

    // req1 reads address 5 back
    set_req(1, 1'b0, 32'd5, 32'h0);
    req_valid = 2'b10;
    mid();
    chk("rd_pulse_gone", rsp_valid, 2'b00);
    chk("rd_accept", req_accept, 2'b10);
    next_cycle();
    req_valid = 2'b00;
    mid();
    chk("rd_setup_write", P_write, 1'b0);
    chk("rd_setup_addr", P_addr, 32'd5);
    next_cycle();
    next_cycle();
    mid();
    chk("rd_rsp_valid", rsp_valid, 2'b10);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    chk("rd_rsp_err", rsp_err, 1'b0);
    next_cycle();
    mid();
    chk("rd_rdata_clear", rsp_rdata, 32'h0);

    // both requesters valid: grants alternate 0,1,0,1 spaced 3 cycles
    next_cycle();
    set_req(0, 1'b0, 32'd5, 32'h0);
    set_req(1, 1'b1, 32'd9, 32'h0000_0009);
    req_valid = 2'b11;
    exp_g  = 2'b01;
    prev_g = 2'b00;
    for (int k = 0; k < 4; k++) begin
      mid();
      chk("rr_accept", req_accept, exp_g);
      if (k > 0) chk("rr_rsp_valid", rsp_valid, prev_g);
      next_cycle();
      if (k == 3) req_valid = 2'b00;
      mid();
      chk("rr_gap1", req_accept, 2'b00);
      next_cycle();
      mid();
      chk("rr_gap2", req_accept, 2'b00);
      next_cycle();
      prev_g = exp_g;
      exp_g  = ~exp_g;
    end
    mid();
    chk("rr_last_rsp", rsp_valid, 2'b10);
    chk("rr_idle_accept", req_accept, 2'b00);
    chk("rr_mem9", mem[9], 32'h0000_0009);

    // P_ready stuck low: abort after TIMEOUT ACCESS cycles
    next_cycle();
    slave_ready = 1'b0;
    set_req(0, 1'b0, 32'd5, 32'h0);
    req_valid = 2'b01;
    mid();
    chk("to_accept", req_accept, 2'b01);
    next_cycle();
    req_valid = 2'b00;
    next_cycle();
    n_acc = 0;
    for (int i = 0; i < 40; i++) begin
      mid();
      if (!P_enable) break;
      n_acc++;
      next_cycle();
    end
    chk("to_access_cycles", n_acc, TIMEOUT);
    chk("to_rsp_valid", rsp_valid, 2'b01);
    chk("to_rsp_err", rsp_err, 1'b1);
    chk("to_rsp_rdata", rsp_rdata, 32'h0);
    chk("to_selx", P_selx, 1'b0);
    next_cycle();
    mid();
    chk("to_err_clear", rsp_err, 1'b0);
    chk("to_valid_clear", rsp_valid, 2'b00);

    // slave error on a read still returns the read data
    next_cycle();
    slave_ready = 1'b1;
    slave_err   = 1'b1;
    set_req(1, 1'b0, 32'd5, 32'h0);
    req_valid = 2'b10;
    mid();
    chk("se_accept", req_accept, 2'b10);
    next_cycle();
    req_valid = 2'b00;
    next_cycle();
    next_cycle();
    mid();
    chk("se_rsp_valid", rsp_valid, 2'b10);
    chk("se_rsp_err", rsp_err, 1'b1);
    chk("se_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    next_cycle();
    slave_err = 1'b0;

    // reset asserted during ACCESS
    slave_ready = 1'b0;
    set_req(1, 1'b0, 32'd7, 32'h0);
    req_valid = 2'b10;
    mid();
    chk("rm_accept", req_accept, 2'b10);
    next_cycle();
    req_valid = 2'b00;
    next_cycle();
    mid();
    chk("rm_in_access", P_enable, 1'b1);
    #2;
    P_rst = 1'b0;
    #1;
    chk("rm_async_selx", P_selx, 1'b0);
    chk("rm_async_enable", P_enable, 1'b0);
    next_cycle();
    P_rst       = 1'b1;
    slave_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("rm_no_rsp", rsp_valid, 2'b00);
      next_cycle();
    end
    req_valid = 2'b11;
    mid();
    chk("rm_first_grant", req_accept, 2'b01);
    next_cycle();
    req_valid = 2'b00;
    repeat (3) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
